// File: rtl/keypad_pkg.sv
// Shared types, polarity constants and helpers for the keypad matrix scanner.
package keypad_pkg;

  localparam int unsigned KP_CODE_W = 8;

  // Board-level polarity: rows are driven low, a closed key pulls its column low.
  localparam logic ROW_DRIVEN = 1'b0;
  localparam logic COL_CLOSED = 1'b0;

  typedef struct packed {
    logic [KP_CODE_W-1:0] code;
    logic                 press;
  } kp_evt_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// First-word-fall-through event FIFO; only instantiated when KEYPAD_EVT_FIFO_EN is defined.
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  kp_evt_t data_i,
  output logic    full_o,
  input  logic    pop_i,
  output kp_evt_t data_o,
  output logic    empty_o
);

  localparam int unsigned AW = clog2_min1(Depth);

  kp_evt_t       mem_q [Depth];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/keypad_matrix_scan.sv
// ROWS x COLS keypad scanner with per-key debounce and a press/release event stream.
// Define KEYPAD_EVT_FIFO_EN to buffer events in a FIFO_DEPTH-entry FIFO instead of one register.
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 25,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CW        = clog2_min1(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COLS-1:0]      col_in,
  output logic [ROWS-1:0]      row_out,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CW-1:0]        evt_code,
  output logic                 evt_press
);

  localparam int unsigned NK  = ROWS * COLS;
  localparam int unsigned RW  = clog2_min1(ROWS);
  localparam int unsigned SW  = clog2_min1(SCAN_DIV);
  localparam int unsigned DW  = clog2_min1(DEBOUNCE + 1);
  localparam int unsigned CCW = clog2_min1(COLS);

  localparam logic [SW-1:0] SlotLast = SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] RowLast  = RW'(ROWS - 1);
  localparam logic [DW-1:0] CntFlip  = DW'(DEBOUNCE - 1);

  logic [COLS-1:0] col_s1_q, col_s_q;
  logic [SW-1:0]   slot_q, slot_d;
  logic [RW-1:0]   row_q, row_d;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic [NK-1:0]   key_state_q, key_state_d;
  logic [DW-1:0]   cnt_q [NK];
  logic [DW-1:0]   cnt_d [NK];
  logic [COLS-1:0] mask_q, mask_d;

  logic            sample, emit, sink_space;
  logic [CCW-1:0]  emit_col;
  logic [CW-1:0]   row_base, emit_code, key_idx;

  assign row_out   = row_out_q;
  assign key_state = key_state_q;

  // Sample once per row slot; a pending mask means this row was already sampled.
  assign sample    = (slot_q == SlotLast) && (mask_q == '0);
  assign row_base  = CW'(row_q) * CW'(COLS);
  assign emit      = (mask_q != '0) && sink_space;
  assign emit_code = row_base + CW'(emit_col);

  always_comb begin
    emit_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (mask_q[c]) emit_col = CCW'(c);
    end
  end

  always_comb begin
    key_state_d = key_state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    key_idx     = '0;
    if (emit) mask_d[emit_col] = 1'b0;
    if (sample) begin
      for (int c = 0; c < COLS; c++) begin
        key_idx = row_base + CW'(c);
        if ((col_s_q[c] == COL_CLOSED) == key_state_q[key_idx]) begin
          cnt_d[key_idx] = '0;
        end else if (cnt_q[key_idx] == CntFlip) begin
          key_state_d[key_idx] = ~key_state_q[key_idx];
          cnt_d[key_idx]       = '0;
          mask_d[c]            = 1'b1;
        end else begin
          cnt_d[key_idx] = cnt_q[key_idx] + 1'b1;
        end
      end
    end
  end

  // The slot parks at its last count until every change of the row has been emitted.
  always_comb begin
    slot_d = slot_q;
    row_d  = row_q;
    if (slot_q != SlotLast) begin
      slot_d = slot_q + 1'b1;
    end else if (mask_d == '0) begin
      slot_d = '0;
      row_d  = (row_q == RowLast) ? '0 : row_q + 1'b1;
    end
    for (int r = 0; r < ROWS; r++) begin
      row_out_d[r] = (RW'(r) == row_d) ? ROW_DRIVEN : ~ROW_DRIVEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q    <= {COLS{~COL_CLOSED}};
      col_s_q     <= {COLS{~COL_CLOSED}};
      slot_q      <= '0;
      row_q       <= '0;
      row_out_q   <= {ROWS{~ROW_DRIVEN}};
      key_state_q <= '0;
      mask_q      <= '0;
      for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
    end else begin
      col_s1_q    <= col_in;
      col_s_q     <= col_s1_q;
      slot_q      <= slot_d;
      row_q       <= row_d;
      row_out_q   <= row_out_d;
      key_state_q <= key_state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef KEYPAD_EVT_FIFO_EN
  kp_evt_t fifo_in, fifo_out;
  logic    fifo_full, fifo_empty;
  logic    unused_fifo_code;

  assign fifo_in.code  = KP_CODE_W'(emit_code);
  assign fifo_in.press = key_state_q[emit_code];
  assign sink_space    = !fifo_full || evt_ready;

  keypad_evt_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (emit),
    .data_i  (fifo_in),
    .full_o  (fifo_full),
    .pop_i   (evt_ready),
    .data_o  (fifo_out),
    .empty_o (fifo_empty)
  );

  assign evt_valid        = !fifo_empty;
  assign evt_code         = fifo_out.code[CW-1:0];
  assign evt_press        = fifo_out.press;
  assign unused_fifo_code = ^fifo_out.code;
`else
  logic          evt_valid_q, evt_valid_d;
  logic [CW-1:0] evt_code_q, evt_code_d;
  logic          evt_press_q, evt_press_d;
  logic [31:0]   unused_fifo_depth;

  assign unused_fifo_depth = 32'(FIFO_DEPTH);
  // Free when empty or when the current event leaves this cycle.
  assign sink_space = !evt_valid_q || evt_ready;

  always_comb begin
    evt_valid_d = evt_valid_q && !evt_ready;
    evt_code_d  = evt_code_q;
    evt_press_d = evt_press_q;
    if (emit) begin
      evt_valid_d = 1'b1;
      evt_code_d  = emit_code;
      evt_press_d = key_state_q[emit_code];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_press_q <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_press_q <= evt_press_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_press = evt_press_q;
`endif

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Bench for keypad_matrix_scan: frame-level key model, event scoreboard and directed checks.
module tb_keypad_matrix_scan;

  localparam int unsigned ROWS       = 4;
  localparam int unsigned COLS       = 4;
  localparam int unsigned SCAN_DIV   = 25;
  localparam int unsigned DEBOUNCE   = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NK         = ROWS * COLS;
  localparam int unsigned CW         = $clog2(NK);
`ifdef KEYPAD_EVT_FIFO_EN
  localparam int unsigned CAP = FIFO_DEPTH;
`else
  localparam int unsigned CAP = 1;
`endif
  localparam int unsigned FRAME_TMO = 40 * ROWS * SCAN_DIV;

  logic            clk, rst_n;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic [NK-1:0]   key_state;
  logic            evt_valid, evt_ready, evt_press;
  logic [CW-1:0]   evt_code;

  keypad_matrix_scan #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE   (DEBOUNCE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical keypad: a held key pulls its column low while its row is driven.
  logic [NK-1:0] keys;
  always_comb begin
    col_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_out[r] && keys[r*COLS+c]) col_in[c] = 1'b0;
  end

  int n_tests, n_fail, cyc;
  int ready_mode;
  bit chk_en, have_frame;

  logic [NK-1:0] mst;
  int            mcnt [NK];
  int            exp_code[$], exp_press[$], dut_code[$], dut_press[$];
  int            log_code[$], log_press[$], log_cyc[$], log_row[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // One complete scan of all rows with a fixed key pattern, in key-index (scan) order.
  task automatic apply_model(input logic [NK-1:0] kf);
    for (int k = 0; k < NK; k++) begin
      if (kf[k] == mst[k]) begin
        mcnt[k] = 0;
      end else begin
        mcnt[k]++;
        if (mcnt[k] == DEBOUNCE) begin
          mst[k]  = kf[k];
          mcnt[k] = 0;
          exp_code.push_back(k);
          exp_press.push_back(int'(kf[k]));
        end
      end
    end
  endtask

  // Wait for the scan to return to row 0, account for the finished frame, then set new keys.
  task automatic next_frame(input logic [NK-1:0] nk);
    int n;
    bit last0, cur0;
    n     = 0;
    last0 = !row_out[0];
    forever begin
      @(negedge clk);
      n++;
      cur0 = !row_out[0];
      if (cur0 && !last0) break;
      last0 = cur0;
      if (n > FRAME_TMO) begin
        chk("frame_timeout", n, 0);
        finish_tb();
      end
    end
    if (have_frame) apply_model(keys);
    chk("key_state", key_state, mst);
    have_frame = 1'b1;
    keys       = nk;
  endtask

  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       evt_ready = 1'b0;
        1:       evt_ready = 1'b1;
        default: evt_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Per-cycle checker: row drive shape, hold stability, and scoreboard of transfers.
  initial begin
    bit            prev_hold;
    logic [CW-1:0] prev_code;
    logic          prev_press;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!chk_en) begin
        prev_hold = 1'b0;
      end else begin
        chk("row_onecold", $countones(~row_out), 1);
        if (prev_hold) begin
          chk("hold_valid", evt_valid, 1);
          chk("hold_code", evt_code, prev_code);
          chk("hold_press", evt_press, prev_press);
        end
        if (evt_valid && evt_ready) begin
          log_code.push_back(int'(evt_code));
          log_press.push_back(int'(evt_press));
          log_cyc.push_back(cyc);
          log_row.push_back(int'(row_out));
          dut_code.push_back(int'(evt_code));
          dut_press.push_back(int'(evt_press));
        end
        while (dut_code.size() > 0 && exp_code.size() > 0) begin
          chk("evt_code", dut_code.pop_front(), exp_code.pop_front());
          chk("evt_press", dut_press.pop_front(), exp_press.pop_front());
        end
        prev_hold  = evt_valid && !evt_ready;
        prev_code  = evt_code;
        prev_press = evt_press;
      end
    end
  end

  initial begin
    int            base, bad;
    logic [NK-1:0] krand, k6, krow0;
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    keys       = '0;
    ready_mode = 1;
    chk_en     = 1'b0;
    have_frame = 1'b0;
    mst        = '0;
    for (int k = 0; k < NK; k++) mcnt[k] = 0;
    k6    = NK'(1) << 6;
    krow0 = NK'((1 << CAP) - 1);

    repeat (3) @(negedge clk);
    chk("rst_row_out", row_out, 4'b1111);
    chk("rst_key_state", key_state, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_code", evt_code, 0);
    chk("rst_evt_press", evt_press, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    next_frame('0);
    chk("first_row", row_out, 4'b1110);
    chk_en = 1'b1;

    // Single press and release of key (1,2).
    base = log_code.size();
    repeat (DEBOUNCE + 1) next_frame(k6);
    chk("press_count", log_code.size() - base, 1);
    chk("press_code", log_code[base], 6);
    chk("press_dir", log_press[base], 1);
    chk("press_state6", key_state[6], 1);
    base = log_code.size();
    repeat (DEBOUNCE + 1) next_frame('0);
    chk("release_count", log_code.size() - base, 1);
    chk("release_code", log_code[base], 6);
    chk("release_dir", log_press[base], 0);

    // Bounce shorter than the debounce window.
    base = log_code.size();
    for (int i = 0; i < 9; i++) next_frame((i % 3 != 2) ? k6 : '0);
    next_frame('0);
    chk("bounce_count", log_code.size() - base, 0);
    chk("bounce_state", key_state, 0);

    // Two keys in one row: ascending codes on consecutive cycles while the row holds.
    base = log_code.size();
    repeat (DEBOUNCE + 1) next_frame(NK'((1 << 8) | (1 << 11)));
    chk("pair_count", log_code.size() - base, 2);
    chk("pair_code0", log_code[base], 8);
    chk("pair_code1", log_code[base+1], 11);
    chk("pair_consec", log_cyc[base+1] - log_cyc[base], 1);
    chk("pair_row", log_row[base], 4'b1011);
    repeat (DEBOUNCE + 1) next_frame('0);

    // Backpressure: one event parked, more changes fill the sink and stall row 0.
    ready_mode = 0;
    base = log_code.size();
    repeat (DEBOUNCE + 1) next_frame(k6);
    repeat (DEBOUNCE) next_frame(k6 | krow0);
    bad = 0;
    repeat (3 * ROWS * SCAN_DIV) begin
      @(negedge clk);
      if (row_out != 4'b1110) bad++;
    end
    chk("stall_row", bad, 0);
    chk("stall_valid", evt_valid, 1);
    chk("stall_code", evt_code, 6);
    chk("stall_none_out", log_code.size() - base, 0);
    ready_mode = 1;
    next_frame(k6 | krow0);
    chk("drain_count", log_code.size() - base, CAP + 1);
    chk("drain_first", log_code[base], 6);
    for (int i = 0; i < CAP; i++) chk("drain_order", log_code[base+1+i], i);
    repeat (DEBOUNCE + 1) next_frame('0);

    // Random key activity with random consumer readiness.
    ready_mode = 2;
    krand = '0;
    for (int f = 0; f < 60; f++) begin
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 4) == 0) krand[k] = ~krand[k];
      next_frame(krand);
    end
    ready_mode = 1;
    repeat (DEBOUNCE + 2) next_frame('0);
    repeat (4) @(negedge clk);
    chk("exp_left", exp_code.size(), 0);
    chk("dut_left", dut_code.size(), 0);
    chk("final_state", key_state, 0);

    // Asynchronous reset mid-scan with an event pending.
    ready_mode = 0;
    repeat (DEBOUNCE + 1) next_frame(NK'(1) << 5);
    repeat (7) @(negedge clk);
    chk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_row_out", row_out, 4'b1111);
    chk("arst_key_state", key_state, 0);
    chk("arst_evt_valid", evt_valid, 0);
    chk("arst_evt_code", evt_code, 0);
    chk("arst_evt_press", evt_press, 0);
    exp_code.delete();
    exp_press.delete();
    dut_code.delete();
    dut_press.delete();
    mst        = '0;
    keys       = '0;
    have_frame = 1'b0;
    for (int k = 0; k < NK; k++) mcnt[k] = 0;
    ready_mode = 1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    next_frame('0);
    chk("rerun_row", row_out, 4'b1110);
    finish_tb();
  end

endmodule
